// File: rtl/ahb_mtx_arb_param.sv
// Output-stage arbiter for one AHB matrix slave port; holds grant over fixed bursts.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module ahb_mtx_arb_param #(
   parameter int                   NUM_PORTS = 8,
   parameter int                   PORT_W    = 3,
   parameter logic [NUM_PORTS-1:0] PORT_MASK = {NUM_PORTS{1'b1}}
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req_port,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic                 no_port,
   output logic                 burst_hold
);

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;

   logic [NUM_PORTS-1:0] eff_req;
   logic [PORT_W-1:0]    pick;
   logic [PORT_W-1:0]    port_nxt;
   logic                 no_port_nxt;
   logic [3:0]           beat_cnt;
   logic [3:0]           beat_nxt;

`ifdef AHB_ARB_ROUND_ROBIN_EN
   logic [PORT_W-1:0]    rr_ptr;
`endif

   // Masked requests, including the port still driving an active transfer.
   always_comb begin
      eff_req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         eff_req[i] = PORT_MASK[i] &
                      (req_port[i] |
                       ((addr_in_port == PORT_W'(i)) & HSELM &
                        (HTRANSM != T_IDLE)));
      end
   end

`ifdef AHB_ARB_ROUND_ROBIN_EN
   // Round-robin search starting just after the last granted port.
   always_comb begin
      logic found;
      int   idx;
      pick  = addr_in_port;
      found = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && eff_req[idx]) begin
            pick  = PORT_W'(idx);
            found = 1'b1;
         end
      end
   end
`else
   // Fixed priority: lowest index wins.
   always_comb begin
      pick = addr_in_port;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (eff_req[i]) pick = PORT_W'(i);
      end
   end
`endif

   // Next grant: lock, then burst hold, then new request, then park.
   always_comb begin
      port_nxt    = addr_in_port;
      no_port_nxt = no_port;
      if (HMASTLOCKM) begin
         no_port_nxt = 1'b0;
      end else if (beat_cnt != 4'd0) begin
         no_port_nxt = 1'b0;
      end else if (|eff_req) begin
         port_nxt    = pick;
         no_port_nxt = 1'b0;
      end else if (!HSELM) begin
         no_port_nxt = 1'b1;
      end
   end

   // Remaining beats of a fixed-length burst.
   always_comb begin
      beat_nxt = beat_cnt;
      if (!HSELM) begin
         beat_nxt = 4'd0;
      end else begin
         case (HTRANSM)
            T_IDLE: beat_nxt = 4'd0;
            T_BUSY: beat_nxt = beat_cnt;
            T_SEQ:  beat_nxt = (beat_cnt != 4'd0) ? beat_cnt - 4'd1 : 4'd0;
            T_NSEQ: begin
               case (HBURSTM)
                  3'b010, 3'b011: beat_nxt = 4'd3;
                  3'b100, 3'b101: beat_nxt = 4'd7;
                  3'b110, 3'b111: beat_nxt = 4'd15;
                  default:        beat_nxt = 4'd0;
               endcase
            end
            default: beat_nxt = beat_cnt;
         endcase
      end
   end

   // Grant and beat counter registers, advanced only on ready cycles.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_in_port <= '0;
         no_port      <= 1'b1;
         beat_cnt     <= 4'd0;
      end else if (HREADYM) begin
         addr_in_port <= port_nxt;
         no_port      <= no_port_nxt;
         beat_cnt     <= beat_nxt;
      end
   end

`ifdef AHB_ARB_ROUND_ROBIN_EN
   // Remember the last port granted or starting a new burst.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rr_ptr <= '0;
      end else if (HREADYM &&
                   ((port_nxt != addr_in_port) ||
                    (HSELM && HTRANSM == T_NSEQ))) begin
         rr_ptr <= port_nxt;
      end
   end
`endif

   assign burst_hold = (beat_cnt != 4'd0);

endmodule

// File: tb/tb_ahb_mtx_arb_param.sv
// Scoreboard bench for ahb_mtx_arb_param: directed vectors, queued expectations.
// Define AHB_ARB_ROUND_ROBIN_EN to run the round-robin sequence.
module tb_ahb_mtx_arb_param;

   localparam logic [1:0] I  = 2'b00;
   localparam logic [1:0] B  = 2'b01;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [1:0] S  = 2'b11;

`ifdef AHB_ARB_ROUND_ROBIN_EN
   localparam logic [7:0] MASK = 8'b1111_1110;
`else
   localparam logic [7:0] MASK = 8'b1111_1111;
`endif

   typedef struct {
      string      nm;
      logic [2:0] a;
      logic       np;
      logic       bh;
   } exp_t;

   logic       HCLK = 1'b0;
   logic       HRESETn;
   logic [7:0] req_port;
   logic       HREADYM;
   logic       HSELM;
   logic [1:0] HTRANSM;
   logic [2:0] HBURSTM;
   logic       HMASTLOCKM;
   logic [2:0] addr_in_port;
   logic       no_port;
   logic       burst_hold;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   ahb_mtx_arb_param #(
      .NUM_PORTS(8),
      .PORT_W(3),
      .PORT_MASK(MASK)
   ) dut (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .req_port(req_port),
      .HREADYM(HREADYM),
      .HSELM(HSELM),
      .HTRANSM(HTRANSM),
      .HBURSTM(HBURSTM),
      .HMASTLOCKM(HMASTLOCKM),
      .addr_in_port(addr_in_port),
      .no_port(no_port),
      .burst_hold(burst_hold)
   );

   always #5 HCLK = ~HCLK;

   // Monitor: pop one expectation per cycle and compare.
   always @(negedge HCLK) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (addr_in_port !== e.a || no_port !== e.np ||
             burst_hold !== e.bh) begin
            errors++;
            $display("FAIL %s: got port=%0d no_port=%0b hold=%0b want port=%0d no_port=%0b hold=%0b",
                     e.nm, addr_in_port, no_port, burst_hold,
                     e.a, e.np, e.bh);
         end
      end
   end

   task automatic push(input string nm, input int a,
                       input logic np, input logic bh);
      exp_t e;
      e.nm = nm;
      e.a  = 3'(a);
      e.np = np;
      e.bh = bh;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs, then queue the state expected after the edge.
   task automatic cyc(input string nm, input logic [7:0] rq,
                      input logic rdy, input logic sel,
                      input logic [1:0] tr, input logic [2:0] bu,
                      input logic lk, input int ea,
                      input logic en, input logic eb);
      req_port   = rq;
      HREADYM    = rdy;
      HSELM      = sel;
      HTRANSM    = tr;
      HBURSTM    = bu;
      HMASTLOCKM = lk;
      @(posedge HCLK);
      #1;
      push(nm, ea, en, eb);
   endtask

   initial begin
      HRESETn    = 1'b0;
      req_port   = '0;
      HREADYM    = 1'b1;
      HSELM      = 1'b0;
      HTRANSM    = I;
      HBURSTM    = 3'b000;
      HMASTLOCKM = 1'b0;
      #2;
      push("reset", 0, 1'b1, 1'b0);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b1;

      cyc("idle0", 8'h00, 1, 0, I, 3'b000, 0, 0, 1, 0);
      cyc("idle1", 8'h00, 1, 0, I, 3'b000, 0, 0, 1, 0);

`ifdef AHB_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= 7; k++) begin
         cyc($sformatf("rr%0d", k), 8'hFF, 1, 0, I, 3'b000, 0, k, 0, 0);
      end
      cyc("rr_wrap", 8'hFF, 1, 0, I, 3'b000, 0, 1, 0, 0);
      cyc("rr_2nd", 8'hFF, 1, 0, I, 3'b000, 0, 2, 0, 0);
      cyc("rr_mask0", 8'h01, 1, 0, I, 3'b000, 0, 2, 1, 0);
`else
      cyc("fp_lo", 8'h2C, 1, 0, I, 3'b000, 0, 2, 0, 0);
      cyc("fp_drop2", 8'h28, 1, 1, I, 3'b000, 0, 3, 0, 0);
      cyc("stall", 8'h01, 0, 0, I, 3'b000, 0, 3, 0, 0);
      cyc("g5", 8'h20, 1, 0, I, 3'b000, 0, 5, 0, 0);
      cyc("i8_ns", 8'h00, 1, 1, NS, 3'b101, 0, 5, 0, 1);
      cyc("i8_s1", 8'h00, 1, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_s2", 8'h00, 1, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_st1", 8'h01, 0, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_s3", 8'h01, 1, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_busy", 8'h01, 1, 1, B, 3'b101, 0, 5, 0, 1);
      cyc("i8_s4", 8'h01, 1, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_st2", 8'h01, 0, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_s5", 8'h01, 1, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_s6", 8'h01, 1, 1, S, 3'b101, 0, 5, 0, 1);
      cyc("i8_s7", 8'h01, 1, 1, S, 3'b101, 0, 5, 0, 0);
      cyc("i8_g0", 8'h01, 1, 1, I, 3'b000, 0, 0, 0, 0);
      cyc("g3", 8'h08, 1, 0, I, 3'b000, 0, 3, 0, 0);
      cyc("w4_ns", 8'h00, 1, 1, NS, 3'b010, 0, 3, 0, 1);
      cyc("w4_s1", 8'h02, 1, 1, S, 3'b010, 0, 3, 0, 1);
      cyc("w4_idle", 8'h02, 1, 1, I, 3'b010, 0, 3, 0, 0);
      cyc("w4_g1", 8'h02, 1, 1, I, 3'b000, 0, 1, 0, 0);
      cyc("g4", 8'h10, 1, 0, I, 3'b000, 0, 4, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc($sformatf("lock%0d", k), 8'h01, 1, 1, NS, 3'b000, 1,
             4, 0, 0);
      end
      cyc("unlock", 8'h01, 1, 0, I, 3'b000, 0, 0, 0, 0);
      cyc("g6", 8'h40, 1, 0, I, 3'b000, 0, 6, 0, 0);
      cyc("i16_ns", 8'h00, 1, 1, NS, 3'b111, 0, 6, 0, 1);
      cyc("i16_s1", 8'h00, 1, 1, S, 3'b111, 0, 6, 0, 1);
      @(negedge HCLK);
      #1;
      HRESETn = 1'b0;
      #1;
      push("mid_rst", 0, 1'b1, 1'b0);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b1;
      cyc("post_rst", 8'h00, 1, 0, I, 3'b000, 0, 0, 1, 0);
`endif

      repeat (3) @(negedge HCLK);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
